stereolbm_mul_arbiter: RTL and testbench



---
 rtl/stereolbm_mul_arbiter.sv | 90 +++++++++
 tb/tb_stereolbm_mul_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stereolbm_mul_arbiter.sv
// Round-robin arbiter that shares one signed x unsigned multiplier among NREQ
// requesters, with a single registered response stage and saturating accept counter.
module stereolbm_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 10,
    parameter int P_WIDTH = 15
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       cfg_enable,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*A_WIDTH-1:0]    req_a,
    input  logic [NREQ*B_WIDTH-1:0]    req_b,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_id,
    output logic [P_WIDTH-1:0]         rsp_data,
    input  logic                       rsp_ready,
    output logic [15:0]                txn_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // Requesters hold valid/operands until accepted; ready depends on valid, never the reverse.

    logic [1:0]         ptr;
    logic [1:0]         cand;
    logic [1:0]         gnt_idx;
    logic               gnt_found;
    logic [NREQ-1:0]    gnt_onehot;
    logic               accept_ok;
    logic               accept;
    logic [A_WIDTH-1:0] a_sel;
    logic [B_WIDTH-1:0] b_sel;
    logic [P_WIDTH-1:0] a_ext;
    logic [P_WIDTH-1:0] b_ext;
    logic [P_WIDTH-1:0] prod;

    // Search starts at ptr; 2-bit index arithmetic wraps modulo 4, matching NREQ.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = ptr;
        gnt_found  = 1'b0;
        cand       = ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + 2'(k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = cand;
                gnt_found        = 1'b1;
            end
        end
    end

    assign accept_ok = cfg_enable && (!rsp_valid || rsp_ready);
    assign req_ready = (ap_rst_n && accept_ok) ? gnt_onehot : '0;
    assign accept    = ap_rst_n && accept_ok && gnt_found;

    assign a_sel = req_a[gnt_idx*A_WIDTH +: A_WIDTH];
    assign b_sel = req_b[gnt_idx*B_WIDTH +: B_WIDTH];

    // Only the low P_WIDTH bits of the product are kept, so multiplying the
    // sign/zero-extended operands modulo 2^P_WIDTH gives the same truncated result.
    assign a_ext = {{(P_WIDTH-A_WIDTH){a_sel[A_WIDTH-1]}}, a_sel};
    assign b_ext = {{(P_WIDTH-B_WIDTH){1'b0}}, b_sel};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 2'd0;
            rsp_data  <= '0;
            ptr       <= 2'd0;
            txn_count <= 16'd0;
        end else begin
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_id    <= gnt_idx;
                rsp_data  <= prod;
                ptr       <= gnt_idx + 2'd1;
                if (txn_count != 16'hFFFF) begin
                    txn_count <= txn_count + 16'd1;
                end
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stereolbm_mul_arbiter.sv
// Directed bench for stereolbm_mul_arbiter: reset, single grant, round robin,
// truncation, backpressure, enable drain and reset mid-stream.
module tb_stereolbm_mul_arbiter;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        cfg_enable;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [39:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [14:0] rsp_data;
    logic        rsp_ready;
    logic [15:0] txn_count;

    int n_cmp  = 0;
    int n_fail = 0;

    stereolbm_mul_arbiter dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .cfg_enable (cfg_enable),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .txn_count  (txn_count)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [7:0] a, input logic [9:0] b);
        req_a[i*8 +: 8]   = a;
        req_b[i*10 +: 10] = b;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [1:0] id,
                             input logic [14:0] data);
        check({tag, "_valid"}, {31'd0, rsp_valid}, {31'd0, v});
        check({tag, "_id"}, {30'd0, rsp_id}, {30'd0, id});
        check({tag, "_data"}, {17'd0, rsp_data}, {17'd0, data});
    endtask

    initial begin
        ap_rst_n   = 1'b0;
        cfg_enable = 1'b1;
        req_valid  = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) set_lane(i, 8'(i + 1), 10'(10 * (i + 1)));

        // Reset: grant suppressed combinationally, registers cleared.
        #2;
        check("rst_ready", {28'd0, req_ready}, 32'h0);
        tick();
        tick();
        check("rst_ready2", {28'd0, req_ready}, 32'h0);
        check_rsp("rst", 1'b0, 2'd0, 15'h0);
        check("rst_txn", {16'd0, txn_count}, 32'd0);

        // Round robin from ptr 0: products 10, 40, 90, 160.
        ap_rst_n = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            logic [14:0] exp_prod;
            exp_prod = 15'((c % 4 + 1) * (c % 4 + 1) * 10);
            check("rr_ready", {28'd0, req_ready}, 32'(1 << (c % 4)));
            tick();
            check_rsp("rr", 1'b1, 2'(c % 4), exp_prod);
        end
        check("rr_txn", {16'd0, txn_count}, 32'd8);

        // Single requester lane 2: -3 * 100 = -300 -> 0x7ED4.
        req_valid = 4'b0100;
        set_lane(2, 8'hFD, 10'd100);
        #1;
        check("single_ready", {28'd0, req_ready}, 32'b0100);
        tick();
        check_rsp("single", 1'b1, 2'd2, 15'h7ED4);
        check("single_txn", {16'd0, txn_count}, 32'd9);
        req_valid = 4'b0000;
        #1;
        check("idle_ready", {28'd0, req_ready}, 32'h0);
        tick();
        check_rsp("drain_hold", 1'b0, 2'd2, 15'h7ED4);

        // Truncation: ptr now 3. Lane 3: -128*1023 -> 0x0080.
        req_valid = 4'b1000;
        set_lane(3, 8'h80, 10'd1023);
        #1;
        check("trunc1_ready", {28'd0, req_ready}, 32'b1000);
        tick();
        check_rsp("trunc1", 1'b1, 2'd3, 15'h0080);
        // Consume and accept together: lane 0 127*1023 -> 0x7B81.
        req_valid = 4'b0001;
        set_lane(0, 8'd127, 10'd1023);
        #1;
        check("trunc2_ready", {28'd0, req_ready}, 32'b0001);
        tick();
        check_rsp("trunc2", 1'b1, 2'd0, 15'h7B81);
        check("trunc_txn", {16'd0, txn_count}, 32'd11);

        // Backpressure with lanes 0,1 valid and ptr 1.
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_ready", {28'd0, req_ready}, 32'h0);
            tick();
            check_rsp("bp_hold", 1'b1, 2'd0, 15'h7B81);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", {28'd0, req_ready}, 32'b0010);
        tick();
        check_rsp("bp_release", 1'b1, 2'd1, 15'd40);
        check("bp_txn", {16'd0, txn_count}, 32'd12);

        // Enable low with a pending result: hold, drain, then no grants.
        req_valid  = 4'b0001;
        cfg_enable = 1'b0;
        rsp_ready  = 1'b0;
        #1;
        check("dis_ready", {28'd0, req_ready}, 32'h0);
        tick();
        check_rsp("dis_hold", 1'b1, 2'd1, 15'd40);
        rsp_ready = 1'b1;
        #1;
        check("dis_ready2", {28'd0, req_ready}, 32'h0);
        tick();
        check_rsp("dis_drain", 1'b0, 2'd1, 15'd40);
        #1;
        check("dis_ready3", {28'd0, req_ready}, 32'h0);
        tick();
        check("dis_valid", {31'd0, rsp_valid}, 32'd0);
        check("dis_txn", {16'd0, txn_count}, 32'd12);

        // Reset mid-stream: accept lane 2 (ptr -> 3), then pulse reset.
        cfg_enable = 1'b1;
        req_valid  = 4'b0100;
        rsp_ready  = 1'b0;
        #1;
        check("pre_rst_ready", {28'd0, req_ready}, 32'b0100);
        tick();
        check_rsp("pre_rst", 1'b1, 2'd2, 15'h7ED4);
        ap_rst_n  = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("mid_rst_ready", {28'd0, req_ready}, 32'h0);
        tick();
        check_rsp("mid_rst", 1'b0, 2'd0, 15'h0);
        check("mid_rst_txn", {16'd0, txn_count}, 32'd0);
        ap_rst_n  = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("post_rst_ready", {28'd0, req_ready}, 32'b0001);
        tick();
        check_rsp("post_rst", 1'b1, 2'd0, 15'h7B81);
        check("post_rst_txn", {16'd0, txn_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
